// File: rtl/tt_um_sai_222777.sv
// tt_um_sai_222777 : TinyTapeout wrapper around a dual-LFSR XOR stream cipher.
// The TX channel encrypts and the RX channel decrypts one bit per enabled clock.
// Seeds, polynomial select and keystream inversion come in through a serial
// config chain that is 2*M+2 bits long and can be daisy-chained via cfg_o.
// Optional feature macro: HEARTBEAT_EN. When it is defined, a free-running
// counter drives uo_out[7:5]. When it is undefined, no counter is built and
// those pins are tied low.
module tt_um_sai_222777 #(
  parameter int          M      = 32,
  parameter logic [31:0] TAPS_A = 32'h8020_0003,
  parameter logic [31:0] TAPS_B = 32'hA300_0000,
  parameter int          HB_W   = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = 2 * M + 2;

  // Pin decode
  logic [1:0] sel;
  logic       tx_p, rx_e, cfg_en, cfg_i, tx_en, rx_en;

  assign sel    = ui_in[1:0];
  assign tx_p   = ui_in[2];
  assign rx_e   = ui_in[3];
  assign cfg_en = ui_in[4];
  assign cfg_i  = ui_in[5];
  assign tx_en  = ui_in[6];
  assign rx_en  = ui_in[7];

  // Architectural state
  logic [CW-1:0] chain_q, chain_d;
  logic          cfg_en_q, cfg_en_d;
  logic [M-1:0]  tx_lfsr_q, tx_lfsr_d;
  logic [M-1:0]  rx_lfsr_q, rx_lfsr_d;
  logic          cfg_poly_q, cfg_poly_d;
  logic          cfg_inv_q, cfg_inv_d;
  logic          tx_e_q, tx_e_d;
  logic          rx_p_q, rx_p_d;
  logic          dbg_tx_p_q, dbg_tx_p_d;
  logic          dbg_rx_e_q, dbg_rx_e_d;
  logic          load;
  logic [2:0]    heartbeat;

  // Fibonacci step: the parity of the tapped bits shifts in at the LSB.
  function automatic logic [M-1:0] lfsr_step(input logic [M-1:0] l, input logic poly);
    logic [M-1:0] taps;
    taps = poly ? TAPS_B[M-1:0] : TAPS_A[M-1:0];
    return {l[M-2:0], ^(l & taps)};
  endfunction

  // The keystream bit comes from the pre-step state. Bypass mode (11) forces
  // zero and ignores the inversion bit.
  function automatic logic key_bit(input logic [M-1:0] l, input logic [1:0] s,
                                   input logic inv);
    logic k;
    case (s)
      2'b00:   k = l[M-1];
      2'b01:   k = l[M-1] ^ l[0];
      2'b10:   k = l[M-1] ^ l[M/2];
      default: k = 1'b0;
    endcase
    if (s != 2'b11) k = k ^ inv;
    return k;
  endfunction

  // The load fires on the first clock with cfg_en low after a clock with it high.
  assign load = cfg_en_q & ~cfg_en;

  // Next-state logic. Config activity (shifting or loading) takes priority and
  // freezes both channels. Otherwise each channel advances on its own enable.
  always_comb begin
    chain_d    = chain_q;
    cfg_en_d   = cfg_en;
    tx_lfsr_d  = tx_lfsr_q;
    rx_lfsr_d  = rx_lfsr_q;
    cfg_poly_d = cfg_poly_q;
    cfg_inv_d  = cfg_inv_q;
    tx_e_d     = tx_e_q;
    rx_p_d     = rx_p_q;
    dbg_tx_p_d = dbg_tx_p_q;
    dbg_rx_e_d = dbg_rx_e_q;
    if (cfg_en) begin
      chain_d = {chain_q[CW-2:0], cfg_i};
    end else if (load) begin
      tx_lfsr_d  = (chain_q[CW-1:M+2] == '0) ? '1 : chain_q[CW-1:M+2];
      rx_lfsr_d  = (chain_q[M+1:2] == '0) ? '1 : chain_q[M+1:2];
      cfg_inv_d  = chain_q[1];
      cfg_poly_d = chain_q[0];
    end else begin
      if (tx_en) begin
        tx_e_d     = tx_p ^ key_bit(tx_lfsr_q, sel, cfg_inv_q);
        dbg_tx_p_d = tx_p;
        tx_lfsr_d  = lfsr_step(tx_lfsr_q, cfg_poly_q);
      end
      if (rx_en) begin
        rx_p_d     = rx_e ^ key_bit(rx_lfsr_q, sel, cfg_inv_q);
        dbg_rx_e_d = rx_e;
        rx_lfsr_d  = lfsr_step(rx_lfsr_q, cfg_poly_q);
      end
    end
  end

  // State registers. Reset returns both LFSRs to all-ones so they never start locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q    <= '0;
      cfg_en_q   <= 1'b0;
      tx_lfsr_q  <= '1;
      rx_lfsr_q  <= '1;
      cfg_poly_q <= 1'b0;
      cfg_inv_q  <= 1'b0;
      tx_e_q     <= 1'b0;
      rx_p_q     <= 1'b0;
      dbg_tx_p_q <= 1'b0;
      dbg_rx_e_q <= 1'b0;
    end else begin
      chain_q    <= chain_d;
      cfg_en_q   <= cfg_en_d;
      tx_lfsr_q  <= tx_lfsr_d;
      rx_lfsr_q  <= rx_lfsr_d;
      cfg_poly_q <= cfg_poly_d;
      cfg_inv_q  <= cfg_inv_d;
      tx_e_q     <= tx_e_d;
      rx_p_q     <= rx_p_d;
      dbg_tx_p_q <= dbg_tx_p_d;
      dbg_rx_e_q <= dbg_rx_e_d;
    end
  end

`ifdef HEARTBEAT_EN
  logic [HB_W-1:0] hb_q, hb_d;

  // Free-running heartbeat counter. Its top three bits give visible activity on the pins.
  always_comb begin
    hb_d = hb_q + HB_W'(1);
  end

  // Heartbeat register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hb_q <= '0;
    else        hb_q <= hb_d;
  end

  assign heartbeat = hb_q[HB_W-1:HB_W-3];
`else
  assign heartbeat = 3'b000;
`endif

  // The chain MSB is a flop output, so cfg_o is registered for daisy-chaining.
  assign uo_out  = {heartbeat, chain_q[CW-1], dbg_rx_e_q, dbg_tx_p_q, rx_p_q, tx_e_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_tt_um_sai_222777.sv
// tb_tt_um_sai_222777 : bench for the dual-LFSR stream cipher.
// A bit-level queue model of the config chain and a behavioural cipher model
// predict uo_out. A negedge process compares the DUT against that prediction
// every cycle. Directed sections add hand-derived literal expectations.
module tb_tt_um_sai_222777;

  localparam logic [31:0] TapsA = 32'h8020_0003;
  localparam logic [31:0] TapsB = 32'hA300_0000;
  localparam int          ChainLen = 66;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_sai_222777 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  // Model state
  bit          cfgQ[$];
  logic [31:0] mTx, mRx;
  bit          mPoly, mInv, mPrevEn;
  bit          mTxE, mRxP, mDbgTx, mDbgRx;
  logic [23:0] hbCount;

  task automatic modelReset();
    cfgQ.delete();
    for (int i = 0; i < ChainLen; i++) cfgQ.push_back(1'b0);
    mTx = '1; mRx = '1;
    mPoly = 0; mInv = 0; mPrevEn = 0;
    mTxE = 0; mRxP = 0; mDbgTx = 0; mDbgRx = 0;
    hbCount = '0;
  endtask

  function automatic logic [31:0] nextState(logic [31:0] l, bit poly);
    logic [31:0] taps;
    taps = poly ? TapsB : TapsA;
    return {l[30:0], 1'($countones(l & taps) % 2)};
  endfunction

  function automatic bit keyBit(logic [31:0] l, logic [1:0] sel, bit inv);
    bit k;
    case (sel)
      2'd0: k = l[31] ^ inv;
      2'd1: k = l[31] ^ l[0] ^ inv;
      2'd2: k = l[31] ^ l[16] ^ inv;
      default: k = 1'b0;
    endcase
    return k;
  endfunction

  // Advance the model by one clock, using the inputs present before the edge.
  task automatic modelClock(input logic [7:0] ui);
    logic [31:0] txSeed, rxSeed;
    if (ui[4]) begin
      cfgQ.push_back(ui[5]);
      void'(cfgQ.pop_front());
    end else if (mPrevEn) begin
      for (int b = 0; b < 32; b++) begin
        txSeed[31-b] = cfgQ[b];
        rxSeed[31-b] = cfgQ[32+b];
      end
      mTx = (txSeed == 0) ? '1 : txSeed;
      mRx = (rxSeed == 0) ? '1 : rxSeed;
      mInv = cfgQ[64];
      mPoly = cfgQ[65];
    end else begin
      if (ui[6]) begin
        mTxE = ui[2] ^ keyBit(mTx, ui[1:0], mInv);
        mDbgTx = ui[2];
        mTx = nextState(mTx, mPoly);
      end
      if (ui[7]) begin
        mRxP = ui[3] ^ keyBit(mRx, ui[1:0], mInv);
        mDbgRx = ui[3];
        mRx = nextState(mRx, mPoly);
      end
    end
    mPrevEn = ui[4];
    hbCount = hbCount + 24'd1;
  endtask

  function automatic logic [7:0] expectedOut();
    logic [2:0] hb;
`ifdef HEARTBEAT_EN
    hb = hbCount[23:21];
`else
    hb = 3'b000;
`endif
    return {hb, cfgQ[0], mDbgRx, mDbgTx, mRxP, mTxE};
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("uo_out", 32'(uo_out), 32'(expectedOut()));
    checkValue("uio_out", 32'(uio_out), 32'h0);
    checkValue("uio_oe", 32'(uio_oe), 32'h0);
  endtask

  // Compare process: the model is settled by mid-cycle.
  always @(negedge clk) if (checkEn) checkOutput();

  // Drive one cycle of inputs, then advance the model after the edge.
  task automatic applyStimulus(input logic [7:0] ui);
    ui_in = ui;
    @(posedge clk);
    #1;
    if (rst_n) modelClock(ui);
  endtask

  task automatic midReset();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkValue("async_reset_low", 32'(uo_out[4:0]), 32'h0);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    rst_n = 1'b1;
  endtask

  task automatic loadZeros(input logic [1:0] sel);
    for (int i = 0; i < ChainLen; i++) applyStimulus(8'h10);
    applyStimulus({6'b0, sel});
  endtask

  logic [15:0] plain, cipher, decrypted;
  logic [65:0] pat, pat2;
  logic [7:0]  ui;
  bit          savedTxE;

  initial begin
    ui_in = 8'h00; uio_in = 8'h00; ena = 1'b1; rst_n = 1'b0;
    modelReset();
    checkEn = 1'b1;
    repeat (3) applyStimulus(8'h00);
    rst_n = 1'b1;

    // Idle after reset
    repeat (100) applyStimulus(8'h00);
    checkValue("idle_low", 32'(uo_out[4:0]), 32'h0);

    // Encrypt 0xF0F0 LSB-first with all-zero config (seeds become all-ones), sel=01
    plain = 16'b1111000011110000;
    loadZeros(2'b01);
    for (int i = 0; i < 16; i++) begin
      applyStimulus({1'b0, 1'b1, 3'b000, plain[i], 2'b01});
      cipher[i] = uo_out[0];
      applyStimulus(8'h01);
    end
    checkValue("cipher_bit1", 32'(cipher[1]), 32'h1);
    checkValue("cipher_bit4", 32'(cipher[4]), 32'h0);
    checkValue("cipher_differs", 32'(cipher != plain), 32'h1);

    // Reset, reload, decrypt on RX
    midReset();
    loadZeros(2'b01);
    for (int i = 0; i < 16; i++) begin
      applyStimulus({1'b1, 3'b000, cipher[i], 1'b0, 2'b01});
      decrypted[i] = uo_out[1];
      applyStimulus(8'h01);
    end
    checkValue("decrypt", 32'(decrypted), 32'h0000F0F0);

    // Bypass mode: both channels pass data straight through
    for (int i = 0; i < 20; i++) begin
      ui = {2'b11, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 2'b11};
      applyStimulus(ui);
      checkValue("bypass_tx", 32'(uo_out[0]), 32'(ui[2]));
      checkValue("bypass_rx", 32'(uo_out[1]), 32'(ui[3]));
    end

    // Daisy chain: shift a known pattern in, then push it out MSB-first
    pat  = {2'($urandom), $urandom, $urandom};
    pat2 = {$urandom, $urandom, 2'b11};
    for (int i = ChainLen - 1; i >= 0; i--) applyStimulus({2'b00, pat[i], 1'b1, 4'b0000});
    for (int i = 0; i < ChainLen; i++) begin
      checkValue("cfg_o_chain", 32'(uo_out[4]), 32'(pat[65-i]));
      applyStimulus({2'b00, pat2[65-i], 1'b1, 4'b0000});
    end
    applyStimulus(8'h00);
    for (int i = 0; i < 64; i++)
      applyStimulus({1'b0, 1'b1, 3'b000, 1'($urandom), 2'($urandom_range(0, 2))});

    // cfg_en wins over tx_en: tx_e holds
    savedTxE = mTxE;
    for (int i = 0; i < 4; i++) begin
      applyStimulus({2'b01, 1'($urandom), 1'b1, 1'b0, ~savedTxE, 2'b00});
      checkValue("cfg_blocks_tx", 32'(uo_out[0]), 32'(savedTxE));
    end
    applyStimulus(8'h00);
    for (int i = 0; i < 8; i++)
      applyStimulus({2'b11, 2'b00, 2'($urandom), 2'($urandom_range(0, 2))});

    // Reset mid-stream: LFSRs back to all-ones, sel=00 gives k=1
    midReset();
    applyStimulus(8'b1100_1000);
    checkValue("post_reset_tx", 32'(uo_out[0]), 32'h1);
    checkValue("post_reset_rx", 32'(uo_out[1]), 32'h0);

    // Random soak with occasional config bursts
    for (int i = 0; i < 1500; i++) begin
      ui = 8'($urandom);
      ui[4] = ($urandom_range(0, 15) == 0);
      applyStimulus(ui);
    end
    repeat (70) applyStimulus({2'b00, 1'($urandom), 1'b1, 4'b0000});
    applyStimulus(8'h00);
    for (int i = 0; i < 200; i++) begin
      ui = 8'($urandom);
      ui[4] = 1'b0;
      applyStimulus(ui);
    end

    @(negedge clk);
    #1;
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
